// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_pkg
// Description : Shared widths, register-zero index and requester encoding
//               for the register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

endpackage : regfile_write_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant between the ALU and load
//               requesters. Keeps the last winner and awards ties to the other.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_reqAlu,
    input  logic i_reqMem,
    output logic o_grantAlu,
    output logic o_grantMem,
    output logic o_lastGrant
);

    logic r_lastGrant;

    // Grants depend only on requests and history, so a grant is a transfer.
    always_comb begin
        o_grantAlu = i_reqAlu && (!i_reqMem || (r_lastGrant == GRANT_MEM));
        o_grantMem = i_reqMem && (!i_reqAlu || (r_lastGrant == GRANT_ALU));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= GRANT_MEM;
        end else if (o_grantAlu) begin
            r_lastGrant <= GRANT_ALU;
        end else if (o_grantMem) begin
            r_lastGrant <= GRANT_MEM;
        end
    end

    assign o_lastGrant = r_lastGrant;

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port between ALU and load
//               write-back, and tracks pending writes for RAW/WAW detection.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_write_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_write_arbiter_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_write_arbiter_pkg::NUM_REGS
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluRegister,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memRegister,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueRegister,
    output logic                  issueStall,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  regWrite
);

    localparam logic [ADDR_WIDTH-1:0] c_zeroReg = ADDR_WIDTH'(ZERO_REG);

    logic                  w_grantAlu;
    logic                  w_grantMem;
    logic                  w_lastGrant;
    logic                  w_transfer;
    logic [ADDR_WIDTH-1:0] w_selRegister;
    logic [DATA_WIDTH-1:0] w_selData;
    logic                  w_issueSet;
    logic [NUM_REGS-1:0]   w_pendingNext;
    logic [NUM_REGS-1:0]   r_pending;

    rr_arbiter2 u_arbiter (
        .clk         (clk),
        .rst         (reset),
        .i_reqAlu    (aluValid),
        .i_reqMem    (memValid),
        .o_grantAlu  (w_grantAlu),
        .o_grantMem  (w_grantMem),
        .o_lastGrant (w_lastGrant)
    );

    assign aluReady = w_grantAlu;
    assign memReady = w_grantMem;

    always_comb begin
        w_transfer    = w_grantAlu || w_grantMem;
        w_selRegister = w_grantAlu ? aluRegister : memRegister;
        w_selData     = w_grantAlu ? aluData     : memData;
    end

    // Writes to register zero are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else if (w_transfer) begin
            regWrite      <= (w_selRegister != c_zeroReg);
            writeRegister <= w_selRegister;
            writeData     <= w_selData;
        end else begin
            regWrite      <= 1'b0;
        end
    end

    always_comb begin
        issueStall = issueValid && r_pending[issueRegister];
        hazard1    = r_pending[readRegister1];
        hazard2    = r_pending[readRegister2];
        w_issueSet = issueValid && !issueStall && (issueRegister != c_zeroReg);
    end

    // Set is applied after clear so a newly issued producer wins a collision.
    always_comb begin
        w_pendingNext = r_pending;
        if (regWrite) begin
            w_pendingNext[writeRegister] = 1'b0;
        end
        if (w_issueSet) begin
            w_pendingNext[issueRegister] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end

    logic w_unusedLastGrant;
    assign w_unusedLastGrant = w_lastGrant;

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluRegister;
    logic [31:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memRegister;
    logic [31:0] memData;
    logic        memReady;
    logic        issueValid;
    logic [4:0]  issueRegister;
    logic        issueStall;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic        hazard1;
    logic        hazard2;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;

    int vectors;
    int miscompares;

    regfile_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .aluValid      (aluValid),
        .aluRegister   (aluRegister),
        .aluData       (aluData),
        .aluReady      (aluReady),
        .memValid      (memValid),
        .memRegister   (memRegister),
        .memData       (memData),
        .memReady      (memReady),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .issueStall    (issueStall),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        aluValid      = 1'b0;
        aluRegister   = '0;
        aluData       = '0;
        memValid      = 1'b0;
        memRegister   = '0;
        memData       = '0;
        issueValid    = 1'b0;
        issueRegister = '0;
        readRegister1 = '0;
        readRegister2 = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_writeRegister", 32'(writeRegister), 32'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_ready", {30'd0, aluReady, memReady}, 32'd0);

        // Single ALU write
        aluValid = 1'b1; aluRegister = 5'd5; aluData = 32'hDEADBEEF;
        #1;
        check("single_aluReady", 32'(aluReady), 32'd1);
        check("single_memReady", 32'(memReady), 32'd0);
        tick();
        aluValid = 1'b0;
        #1;
        check("single_regWrite", 32'(regWrite), 32'd1);
        check("single_writeRegister", 32'(writeRegister), 32'd5);
        check("single_writeData", writeData, 32'hDEADBEEF);
        tick();
        check("single_regWrite_drop", 32'(regWrite), 32'd0);
        check("single_hold_data", writeData, 32'hDEADBEEF);

        // Single load write so the next tie starts with ALU
        memValid = 1'b1; memRegister = 5'd6; memData = 32'h66;
        #1;
        check("memonly_ready", {30'd0, aluReady, memReady}, 32'd1);
        tick();
        memValid = 1'b0;
        #1;
        check("memonly_writeRegister", 32'(writeRegister), 32'd6);
        check("memonly_writeData", writeData, 32'h66);
        tick();

        // Contention: expected grants ALU, MEM, ALU, MEM
        aluValid = 1'b1; aluRegister = 5'd3; aluData = 32'h11;
        memValid = 1'b1; memRegister = 5'd4; memData = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready_pair", {30'd0, aluReady, memReady}, (k % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            check("rr_writeRegister", 32'(writeRegister), (k % 2 == 0) ? 32'd3 : 32'd4);
            check("rr_writeData", writeData, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        aluValid = 1'b0; memValid = 1'b0;
        tick();

        // RAW scoreboard on r7
        issueValid = 1'b1; issueRegister = 5'd7; readRegister1 = 5'd7;
        #1;
        check("raw_issueStall", 32'(issueStall), 32'd0);
        check("raw_hazard_before", 32'(hazard1), 32'd0);
        tick();
        issueValid = 1'b0;
        #1;
        check("raw_hazard_set", 32'(hazard1), 32'd1);
        memValid = 1'b1; memRegister = 5'd7; memData = 32'h55;
        #1;
        check("raw_memReady", 32'(memReady), 32'd1);
        tick();
        memValid = 1'b0;
        #1;
        check("raw_regWrite", 32'(regWrite), 32'd1);
        check("raw_hazard_during_write", 32'(hazard1), 32'd1);
        tick();
        check("raw_hazard_cleared", 32'(hazard1), 32'd0);

        // WAW stall on r9
        issueValid = 1'b1; issueRegister = 5'd9; readRegister2 = 5'd9;
        tick();
        check("waw_hazard2_set", 32'(hazard2), 32'd1);
        check("waw_issueStall", 32'(issueStall), 32'd1);
        tick();
        issueValid = 1'b0;
        #1;
        check("waw_bit_stays", 32'(hazard2), 32'd1);
        // Retire r9 so the next write can collide with a fresh issue
        aluValid = 1'b1; aluRegister = 5'd9; aluData = 32'h99;
        tick();
        aluValid = 1'b0;
        tick();
        check("waw_cleared", 32'(hazard2), 32'd0);
        aluValid = 1'b1; aluRegister = 5'd9; aluData = 32'h9A;
        tick();
        aluValid = 1'b0;
        issueValid = 1'b1; issueRegister = 5'd9;
        #1;
        check("collide_regWrite", 32'(regWrite), 32'd1);
        check("collide_issueStall", 32'(issueStall), 32'd0);
        tick();
        issueValid = 1'b0;
        #1;
        check("collide_set_wins", 32'(hazard2), 32'd1);

        // Register zero
        aluValid = 1'b1; aluRegister = 5'd0; aluData = 32'hFFFF; readRegister1 = 5'd0;
        #1;
        check("zero_aluReady", 32'(aluReady), 32'd1);
        tick();
        aluValid = 1'b0;
        issueValid = 1'b1; issueRegister = 5'd0;
        #1;
        check("zero_regWrite", 32'(regWrite), 32'd0);
        check("zero_issueStall", 32'(issueStall), 32'd0);
        tick();
        issueValid = 1'b0;
        #1;
        check("zero_hazard1", 32'(hazard1), 32'd0);

        // Reset mid-operation with pending {3,9}
        issueValid = 1'b1; issueRegister = 5'd3; readRegister1 = 5'd3;
        tick();
        issueValid = 1'b0;
        aluValid = 1'b1; aluRegister = 5'd5; aluData = 32'h1234;
        #1;
        check("mid_hazards", {30'd0, hazard1, hazard2}, 32'd3);
        tick();
        aluValid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_regWrite_before", 32'(regWrite), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("mid_regWrite_after", 32'(regWrite), 32'd0);
        check("mid_hazards_after", {30'd0, hazard1, hazard2}, 32'd0);
        check("mid_writeRegister", 32'(writeRegister), 32'd0);
        aluValid = 1'b1; memValid = 1'b1;
        #1;
        check("mid_first_tie", {30'd0, aluReady, memReady}, 32'd2);
        aluValid = 1'b0; memValid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: the ALU result path and the load/memory path.
- Uses a valid/ready handshake and round-robin arbitration.
- Keeps a 32-entry pending-write scoreboard and flags read-after-write hazards on both read ports, plus write-after-write conflicts at issue.
- Sits between the execute/memory stages and the register file; drives the register file's writeRegister/writeData/regWrite inputs.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of registers (2**ADDR_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- aluValid  in  1  ALU has a write-back pending.
- aluRegister  in  ADDR_WIDTH  ALU destination register.
- aluData  in  DATA_WIDTH  ALU result.
- aluReady  out  1  ALU request accepted this cycle.
- memValid  in  1  load unit has a write-back pending.
- memRegister  in  ADDR_WIDTH  load destination register.
- memData  in  DATA_WIDTH  load data.
- memReady  out  1  load request accepted this cycle.
- issueValid  in  1  decode issues an instruction that writes a register.
- issueRegister  in  ADDR_WIDTH  destination of the issuing instruction.
- issueStall  out  1  issue refused: destination already pending (WAW).
- readRegister1  in  ADDR_WIDTH  register file read port 1 index.
- readRegister2  in  ADDR_WIDTH  register file read port 2 index.
- hazard1  out  1  readRegister1 has a pending write.
- hazard2  out  1  readRegister2 has a pending write.
- writeRegister  out  ADDR_WIDTH  to register file.
- writeData  out  DATA_WIDTH  to register file.
- regWrite  out  1  to register file write enable.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - regWrite=0, writeRegister=0, writeData=0.
  - pending bitmap all 0.
  - lastGrant=MEM, so the ALU wins the first tie.
  - Reset overrides any handshake or issue in the same cycle; in-flight requests are dropped and requesters must re-present them.
- Arbitration is combinational each cycle:
  - Only aluValid: aluReady=1.
  - Only memValid: memReady=1.
  - Both valid: grant the requester not equal to lastGrant.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle. Ready never depends on the requester's ready state; it depends only on valid and lastGrant.
- Handshake: a transfer occurs at an edge where valid&&ready.
  - Requester holds register and data stable while valid && !ready.
  - Valid may drop without a transfer; no error.
- Output register, latency 1:
  - On a transfer, at the next edge: writeRegister/writeData take the granted requester's values, regWrite=1, and lastGrant updates to the winner.
  - With no transfer: regWrite=0; writeRegister and writeData hold their previous values.
  - The register file commits at the edge after that, so total latency from handshake edge to data in the register file is 2 edges.
- Register 0 is hardwired zero:
  - A transfer to register 0 is accepted (ready=1) but regWrite stays 0.
  - The transfer still counts for lastGrant.
- Scoreboard (pending[NUM_REGS]):
  - Set: at the edge with issueValid && !issueStall && issueRegister!=0, set pending[issueRegister].
  - Clear: at the edge where regWrite=1, clear pending[writeRegister].
  - Set and clear of the same index at the same edge: set wins (the new producer is issued).
  - issueStall = issueValid && pending[issueRegister], combinational. For issueRegister=0 it is always 0.
  - hazardN = pending[readRegisterN], combinational. Register 0 is always 0.
  - The bypass case is not covered: a write landing this edge still shows a hazard this cycle. Decode stalls one extra cycle.
- No overflow or wrap conditions; the bitmap is bounded by NUM_REGS.

Decomposition:
- Shared package holds:
  - ADDR_WIDTH, DATA_WIDTH, NUM_REGS.
  - localparam ZERO_REG=0.
  - Requester encoding GRANT_ALU=1'b0, GRANT_MEM=1'b1.
- One sub-module: rr_arbiter2 (2-way round-robin grant plus lastGrant flop, with its own reset).
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset then single write: after reset, aluValid=1, aluRegister=5, aluData=32'hDEADBEEF.
  - aluReady=1 in the same cycle.
  - Next cycle: regWrite=1, writeRegister=5, writeData=DEADBEEF.
  - Following cycle: regWrite=0.
- Contention round-robin: both valid for 4 cycles (alu r3=0x11, mem r4=0x22, re-presented after each accept).
  - Grant order is ALU, MEM, ALU, MEM.
  - Never both ready high.
- Scoreboard RAW: issue r7; readRegister1=7.
  - hazard1=1 the cycle after issue.
  - memValid writes r7=0x55; hazard1 stays 1 until the edge where regWrite=1 for r7, then 0.
- WAW and set/clear collision:
  - Issue r9 while pending[9]=1 → issueStall=1 and the bit stays 1.
  - Issue r9 on the same edge that regWrite clears r9 → pending[9]=1 afterwards.
- Register zero: aluValid with aluRegister=0, data 0xFFFF.
  - aluReady=1; regWrite stays 0.
  - hazard1 with readRegister1=0 is always 0.
  - issueValid r0 sets nothing.
- Reset mid-operation: assert reset while regWrite=1 and pending bits {3,9}.
  - Next cycle: regWrite=0, all hazards 0.
  - First tie after reset goes to ALU.
